// File: rtl/pattern_frame_gen_det_if.sv
// pattern_frame_gen_det_if: control, serial line and detector signals of the frame generator/detector.
interface pattern_frame_gen_det_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
);
  logic             GO;
  logic [SEL_W-1:0] MODE;
  logic             REPEAT;
  logic             SIG;
  logic             SYNC;
  logic             BUSY;
  logic             DONE;
  logic             RX_SIG;
  logic             RX_SYNC;
  logic             CLR_CNT;
  logic             SEQ;
  logic [CNT_W-1:0] MATCH_CNT;
  modport master (
    output GO, MODE, REPEAT, RX_SIG, RX_SYNC, CLR_CNT,
    input  SIG, SYNC, BUSY, DONE, SEQ, MATCH_CNT
  );
  modport slave (
    input  GO, MODE, REPEAT, RX_SIG, RX_SYNC, CLR_CNT,
    output SIG, SYNC, BUSY, DONE, SEQ, MATCH_CNT
  );
endinterface

// File: rtl/pattern_frame_gen_det.sv
// pattern_frame_gen_det: serial frame generator from a pattern table plus an independent frame detector with match counter.
module pattern_frame_gen_det #(
  parameter int                              FRAME_W   = 4,
  parameter int                              SEL_W     = 2,
  parameter logic [FRAME_W*(2**SEL_W)-1:0]   PAT_TABLE = {4'b1111, 4'b0110, 4'b0101, 4'b1001},
  parameter logic [FRAME_W-1:0]              MATCH_PAT = 4'b0110,
  parameter bit                              MSB_FIRST = 1'b0,
  parameter int                              CNT_W     = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  pattern_frame_gen_det_if.slave  bus
);
  localparam int IW = $clog2(FRAME_W + 1);
  localparam int CW = $clog2(FRAME_W);
  localparam logic [IW-1:0] IDX_END  = IW'(FRAME_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_W - 1);
  typedef enum logic {IDLE, SEND} gen_t;
  typedef enum logic {WAIT, COLLECT} det_t;
  // Table entries stored in transmit order so the generator always shifts out bit 0
  logic [FRAME_W-1:0] ent [2**SEL_W];
  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_ent
    for (genvar b = 0; b < FRAME_W; b++) begin : g_bit
      assign ent[g][b] = PAT_TABLE[g*FRAME_W + (MSB_FIRST ? FRAME_W-1-b : b)];
    end
  end
  gen_t               gst_q, gst_d;
  logic [FRAME_W-1:0] pat_q, pat_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               sig_q, sig_d, sync_q, sync_d, busy_q, busy_d, done_q, done_d;
  logic [FRAME_W-1:0] ent_sel;
  logic               start, sending, at_end;
  det_t               dst_q, dst_d;
  logic [FRAME_W-1:0] word_q, word_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               seq_q, seq_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic               take, last;
  assign ent_sel = ent[bus.MODE];
  assign at_end  = (gst_q == SEND) && (idx_q == IDX_END);
  assign sending = (gst_q == SEND) && (idx_q != IDX_END);
  assign start   = (gst_q == IDLE) ? bus.GO : at_end && bus.REPEAT;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      gst_q <= IDLE;
      dst_q <= WAIT;
    end else begin
      gst_q <= gst_d;
      dst_q <= dst_d;
    end
  always_comb gst_d = start ? SEND : at_end ? IDLE : gst_q;
  always_comb begin
    pat_d  = start ? ent_sel >> 1 : pat_q >> 1;
    idx_d  = start ? IW'(1) : sending ? idx_q + 1'b1 : idx_q;
    sig_d  = start ? ent_sel[0] : sending ? pat_q[0] : 1'b0;
    sync_d = start;
    busy_d = start | sending;
    done_d = at_end && !bus.REPEAT;
  end
  // A SYNC always restarts collection, aborting any partial frame
  assign take = bus.RX_SYNC | (dst_q == COLLECT);
  assign last = !bus.RX_SYNC && (dst_q == COLLECT) && (cnt_q == CNT_LAST);
  always_comb dst_d = bus.RX_SYNC ? COLLECT : last ? WAIT : dst_q;
  always_comb begin
    word_d = !take ? word_q :
             MSB_FIRST ? {word_q[FRAME_W-2:0], bus.RX_SIG} : {bus.RX_SIG, word_q[FRAME_W-1:1]};
    cnt_d  = bus.RX_SYNC ? CW'(1) : (dst_q == COLLECT) ? cnt_q + 1'b1 : cnt_q;
    seq_d  = last && (word_d == MATCH_PAT);
    mcnt_d = bus.CLR_CNT ? '0 : (seq_q && mcnt_q != '1) ? mcnt_q + 1'b1 : mcnt_q;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      pat_q  <= '0;
      idx_q  <= '0;
      sig_q  <= 1'b0;
      sync_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      word_q <= '0;
      cnt_q  <= '0;
      seq_q  <= 1'b0;
      mcnt_q <= '0;
    end else begin
      pat_q  <= pat_d;
      idx_q  <= idx_d;
      sig_q  <= sig_d;
      sync_q <= sync_d;
      busy_q <= busy_d;
      done_q <= done_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      seq_q  <= seq_d;
      mcnt_q <= mcnt_d;
    end
  assign bus.SIG       = sig_q;
  assign bus.SYNC      = sync_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.SEQ       = seq_q;
  assign bus.MATCH_CNT = mcnt_q;
endmodule

// File: tb/tb_pattern_frame_gen_det.sv
// tb_pattern_frame_gen_det: directed checks of generator, loopback detection, counter saturation and reset.
module tb_pattern_frame_gen_det;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lb0 = 1'b1;
  logic ext_sig = 1'b0;
  logic ext_sync = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  pattern_frame_gen_det_if #(.SEL_W(2), .CNT_W(8)) b0 ();
  pattern_frame_gen_det_if #(.SEL_W(2), .CNT_W(2)) b1 ();
  pattern_frame_gen_det_if #(.SEL_W(2), .CNT_W(8)) b2 ();
  assign b0.RX_SIG  = lb0 ? b0.SIG : ext_sig;
  assign b0.RX_SYNC = lb0 ? b0.SYNC : ext_sync;
  assign b1.RX_SIG  = b1.SIG;
  assign b1.RX_SYNC = b1.SYNC;
  assign b2.RX_SIG  = b2.SIG;
  assign b2.RX_SYNC = b2.SYNC;
  pattern_frame_gen_det #(.CNT_W(8)) u0 (.CLK(clk), .RST_N(rst_n), .bus(b0.slave));
  pattern_frame_gen_det #(.CNT_W(2)) u1 (.CLK(clk), .RST_N(rst_n), .bus(b1.slave));
  pattern_frame_gen_det #(.MSB_FIRST(1'b1)) u2 (.CLK(clk), .RST_N(rst_n), .bus(b2.slave));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b0.SIG, b0.SYNC, b0.BUSY, b0.DONE, b0.SEQ} !== 5'b0) begin
      failures++; $display("FAIL reset_outs got=%b want=00000", {b0.SIG, b0.SYNC, b0.BUSY, b0.DONE, b0.SEQ});
    end
    checks++;
    if (b0.MATCH_CNT !== 8'd0 || b1.MATCH_CNT !== 2'd0 || b2.BUSY !== 1'b0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d/%b want=0/0/0", b0.MATCH_CNT, b1.MATCH_CNT, b2.BUSY);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [3:0] s, y, b;
    logic q;
    q = 1'b0; lb0 = 1'b0;
    b0.MODE = 2'd0; b0.GO = 1'b1;
    @(negedge clk); b0.GO = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {b0.SIG, s[3:1]}; y = {b0.SYNC, y[3:1]}; b = {b0.BUSY, b[3:1]}; q |= b0.SEQ;
      @(negedge clk);
    end
    checks++;
    if (s !== 4'b1001) begin failures++; $display("FAIL mode0_sig got=%b want=1001", s); end
    checks++;
    if (y !== 4'b0001) begin failures++; $display("FAIL mode0_sync got=%b want=0001", y); end
    checks++;
    if (b !== 4'b1111) begin failures++; $display("FAIL mode0_busy got=%b want=1111", b); end
    checks++;
    if ({b0.DONE, b0.BUSY, b0.SIG} !== 3'b100) begin
      failures++; $display("FAIL mode0_done got=%b want=100", {b0.DONE, b0.BUSY, b0.SIG});
    end
    q |= b0.SEQ;
    @(negedge clk);
    checks++;
    if (b0.DONE !== 1'b0) begin failures++; $display("FAIL mode0_done_pulse got=%b want=0", b0.DONE); end
    checks++;
    if ((q | b0.SEQ) !== 1'b0) begin failures++; $display("FAIL mode0_seq got=%b want=0", q | b0.SEQ); end
  endtask

  task automatic test_go_held();
    logic [8:0] s, y, b;
    b0.MODE = 2'd0; b0.GO = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      s = {b0.SIG, s[8:1]}; y = {b0.SYNC, y[8:1]}; b = {b0.BUSY, b[8:1]};
      if (i == 5) b0.GO = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (s !== 9'b100101001) begin failures++; $display("FAIL goheld_sig got=%b want=100101001", s); end
    checks++;
    if (b !== 9'b111101111) begin failures++; $display("FAIL goheld_busy got=%b want=111101111", b); end
    checks++;
    if (y !== 9'b000100001) begin failures++; $display("FAIL goheld_sync got=%b want=000100001", y); end
    checks++;
    if (b0.DONE !== 1'b1) begin failures++; $display("FAIL goheld_done got=%b want=1", b0.DONE); end
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [3:0] s;
    logic q;
    q = 1'b0; lb0 = 1'b1;
    b0.MODE = 2'd2; b0.GO = 1'b1;
    @(negedge clk); b0.GO = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {b0.SIG, s[3:1]}; q |= b0.SEQ;
      @(negedge clk);
    end
    checks++;
    if (s !== 4'b0110) begin failures++; $display("FAIL loop_sig got=%b want=0110", s); end
    checks++;
    if ({q, b0.SEQ, b0.DONE} !== 3'b011) begin
      failures++; $display("FAIL loop_seq_timing got=%b want=011", {q, b0.SEQ, b0.DONE});
    end
    @(negedge clk);
    checks++;
    if (b0.SEQ !== 1'b0 || b0.MATCH_CNT !== 8'd1) begin
      failures++; $display("FAIL loop_cnt got=seq%b cnt%0d want=seq0 cnt1", b0.SEQ, b0.MATCH_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] s, y, b;
    int nseq, ndone;
    nseq = 0; ndone = 0;
    b0.MODE = 2'd2; b0.REPEAT = 1'b1; b0.GO = 1'b1;
    @(negedge clk); b0.GO = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i < 12) begin s = {b0.SIG, s[11:1]}; y = {b0.SYNC, y[11:1]}; b = {b0.BUSY, b[11:1]}; end
      nseq += int'(b0.SEQ); ndone += int'(b0.DONE);
      if (i == 8) b0.REPEAT = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (s !== 12'b011001100110) begin failures++; $display("FAIL b2b_sig got=%b want=011001100110", s); end
    checks++;
    if (y !== 12'b000100010001) begin failures++; $display("FAIL b2b_sync got=%b want=000100010001", y); end
    checks++;
    if (b !== 12'hfff) begin failures++; $display("FAIL b2b_busy got=%h want=fff", b); end
    checks++;
    if (nseq != 3 || ndone != 1) begin failures++; $display("FAIL b2b_counts got=seq%0d done%0d want=seq3 done1", nseq, ndone); end
    checks++;
    if (b0.MATCH_CNT !== 8'd4) begin failures++; $display("FAIL b2b_cnt got=%0d want=4", b0.MATCH_CNT); end
  endtask

  task automatic test_midframe();
    logic [3:0] s;
    b0.MODE = 2'd2; b0.GO = 1'b1;
    @(negedge clk); b0.GO = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {b0.SIG, s[3:1]};
      if (i == 1) begin b0.MODE = 2'd3; b0.GO = 1'b1; end
      if (i == 2) b0.GO = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (s !== 4'b0110) begin failures++; $display("FAIL mid_sig got=%b want=0110", s); end
    checks++;
    if ({b0.SEQ, b0.DONE} !== 2'b11) begin failures++; $display("FAIL mid_end got=%b want=11", {b0.SEQ, b0.DONE}); end
    @(negedge clk);
    checks++;
    if (b0.BUSY !== 1'b0 || b0.MATCH_CNT !== 8'd5) begin
      failures++; $display("FAIL mid_restart got=busy%b cnt%0d want=busy0 cnt5", b0.BUSY, b0.MATCH_CNT);
    end
    b0.MODE = 2'd2;
  endtask

  task automatic test_resync();
    logic [9:0] d, y;
    logic [11:0] q;
    d = 10'b0110000110; y = 10'b0001000101; lb0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      q = {b0.SEQ, q[11:1]};
      ext_sig = d[0]; ext_sync = y[0];
      d = d >> 1; y = y >> 1;
      @(negedge clk);
    end
    checks++;
    if (q !== 12'h400) begin failures++; $display("FAIL resync_seq got=%h want=400", q); end
    checks++;
    if (b0.MATCH_CNT !== 8'd6) begin failures++; $display("FAIL resync_cnt got=%0d want=6", b0.MATCH_CNT); end
    lb0 = 1'b1;
  endtask

  task automatic test_saturate();
    int nseq;
    nseq = 0;
    b1.MODE = 2'd2; b1.REPEAT = 1'b1; b1.GO = 1'b1;
    @(negedge clk); b1.GO = 1'b0;
    for (int i = 0; i < 22; i++) begin
      nseq += int'(b1.SEQ);
      if (i == 16) b1.REPEAT = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (nseq != 5) begin failures++; $display("FAIL sat_seqs got=%0d want=5", nseq); end
    checks++;
    if (b1.MATCH_CNT !== 2'd3) begin failures++; $display("FAIL sat_cnt got=%0d want=3", b1.MATCH_CNT); end
  endtask

  task automatic test_clear();
    b1.GO = 1'b1;
    @(negedge clk); b1.GO = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (b1.SEQ !== 1'b1 || b1.MATCH_CNT !== 2'd3) begin
      failures++; $display("FAIL clr_pre got=seq%b cnt%0d want=seq1 cnt3", b1.SEQ, b1.MATCH_CNT);
    end
    b1.CLR_CNT = 1'b1;
    @(negedge clk); b1.CLR_CNT = 1'b0;
    checks++;
    if (b1.MATCH_CNT !== 2'd0) begin failures++; $display("FAIL clr_wins got=%0d want=0", b1.MATCH_CNT); end
    @(negedge clk);
    checks++;
    if (b1.MATCH_CNT !== 2'd0) begin failures++; $display("FAIL clr_hold got=%0d want=0", b1.MATCH_CNT); end
  endtask

  task automatic test_reset_midframe();
    logic any;
    any = 1'b0;
    b0.MODE = 2'd2; b0.GO = 1'b1;
    @(negedge clk); b0.GO = 1'b0;
    @(negedge clk);
    checks++;
    if ({b0.BUSY, b0.SIG} !== 2'b11) begin failures++; $display("FAIL rstmid_pre got=%b want=11", {b0.BUSY, b0.SIG}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b0.SIG, b0.SYNC, b0.BUSY, b0.DONE, b0.SEQ} !== 5'b0 || b0.MATCH_CNT !== 8'd0) begin
      failures++; $display("FAIL rstmid_async got=%b cnt%0d want=00000 cnt0", {b0.SIG, b0.SYNC, b0.BUSY, b0.DONE, b0.SEQ}, b0.MATCH_CNT);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      any |= b0.SIG | b0.DONE | b0.SEQ | b0.BUSY;
    end
    checks++;
    if (any !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b want=0", any); end
  endtask

  task automatic test_msb_first();
    logic [3:0] s;
    int nseq;
    nseq = 0;
    b2.MODE = 2'd1; b2.GO = 1'b1;
    @(negedge clk); b2.GO = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {b2.SIG, s[3:1]};
      @(negedge clk);
    end
    checks++;
    if (s !== 4'b1010) begin failures++; $display("FAIL msb_sig got=%b want=1010", s); end
    b2.MODE = 2'd2; b2.GO = 1'b1;
    @(negedge clk); b2.GO = 1'b0;
    repeat (7) begin
      nseq += int'(b2.SEQ);
      @(negedge clk);
    end
    checks++;
    if (nseq != 1 || b2.MATCH_CNT !== 8'd1) begin
      failures++; $display("FAIL msb_match got=seq%0d cnt%0d want=seq1 cnt1", nseq, b2.MATCH_CNT);
    end
  endtask

  initial begin
    b0.GO = 1'b0; b0.MODE = 2'd0; b0.REPEAT = 1'b0; b0.CLR_CNT = 1'b0;
    b1.GO = 1'b0; b1.MODE = 2'd0; b1.REPEAT = 1'b0; b1.CLR_CNT = 1'b0;
    b2.GO = 1'b0; b2.MODE = 2'd0; b2.REPEAT = 1'b0; b2.CLR_CNT = 1'b0;
    test_reset();
    test_mode0();
    test_go_held();
    test_loopback();
    test_back_to_back();
    test_midframe();
    test_resync();
    test_saturate();
    test_clear();
    test_reset_midframe();
    test_msb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
